// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-requester (I-cache refill / D-cache) single-port memory arbiter
//
// Purpose: serialises I and D cache requests onto one memory port. D normally
// wins; once I has watched MAX_WAIT D grants go by while requesting, I is
// forced through. One transaction at a time, each followed by a DONE cycle.
//
// Ports:
//   clk, rst                  clock, asynchronous active-low reset
//   i_req, i_addr             I refill request and byte address
//   i_rdata, i_done           I refill block and one-cycle completion pulse
//   d_req, d_we, d_addr,
//   d_wdata                   D request, write enable, address, write block
//   d_rdata, d_done           D read block and one-cycle completion pulse
//   mem_req, mem_we, mem_addr,
//   mem_wdata                 memory request and latched command
//   mem_rdata, mem_ack        memory read block and completion
//   owner                     00 none, 01 I, 10 D
module mem_arbiter #(
   parameter int DATA_W   = 128,
   parameter int MAX_WAIT = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_req,
   input  logic [31:0]       i_addr,
   output logic [DATA_W-1:0] i_rdata,
   output logic              i_done,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [31:0]       d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_done,
   output logic              mem_req,
   output logic              mem_we,
   output logic [31:0]       mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack,
   output logic [1:0]        owner
);

   typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, DONE} state_t;

   state_t     state;
   state_t     next_state;
   logic [2:0] wait_cnt;
   logic       starved;
   logic       grant_i;
   logic       grant_d;
   logic       ack_i;
   logic       ack_d;

   // I has waited long enough that it must beat a pending D request
   assign starved = i_req && (32'(wait_cnt) >= MAX_WAIT);
   assign ack_i   = (state == BUSY_I) && mem_ack;
   assign ack_d   = (state == BUSY_D) && mem_ack;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      grant_i    = 1'b0;
      grant_d    = 1'b0;
      case (state)
         IDLE: begin
            if (d_req && !starved) begin
               grant_d    = 1'b1;
               next_state = BUSY_D;
            end else if (i_req) begin
               grant_i    = 1'b1;
               next_state = BUSY_I;
            end
         end
         BUSY_I, BUSY_D: begin
            if (mem_ack) begin
               next_state = DONE;
            end
         end
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // mem_req and owner decode straight from state so that reset clears them
   // without waiting for a clock edge
   always_comb begin
      mem_req = 1'b0;
      owner   = 2'b00;
      case (state)
         BUSY_I: begin
            mem_req = 1'b1;
            owner   = 2'b01;
         end
         BUSY_D: begin
            mem_req = 1'b1;
            owner   = 2'b10;
         end
         default: begin
            mem_req = 1'b0;
            owner   = 2'b00;
         end
      endcase
   end

   // Command is captured only at grant, so requester inputs may change or
   // drop freely while the transaction is in flight.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mem_addr  <= '0;
         mem_we    <= 1'b0;
         mem_wdata <= '0;
         wait_cnt  <= '0;
         i_done    <= 1'b0;
         d_done    <= 1'b0;
         i_rdata   <= '0;
         d_rdata   <= '0;
      end else begin
         if (grant_d) begin
            mem_addr  <= d_addr;
            mem_we    <= d_we;
            mem_wdata <= d_wdata;
            if (i_req && (wait_cnt != 3'd7)) begin
               wait_cnt <= wait_cnt + 3'd1;
            end
         end else if (grant_i) begin
            mem_addr  <= i_addr;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
            wait_cnt  <= '0;
         end
         // done is high exactly during DONE, which lasts one cycle
         i_done <= ack_i;
         d_done <= ack_d;
         if (ack_i) begin
            i_rdata <= mem_rdata;
         end
         if (ack_d) begin
            d_rdata <= mem_we ? '0 : mem_rdata;
         end
      end
   end

endmodule
